// File: rtl/fifo_wr_packer.sv
// Packs pack_n narrow pixels into one FIFO write word, pads short words at end of line,
// holds the word against FIFO full and tracks line count / line-length errors.
module fifo_wr_packer #(
  parameter int unsigned       in_dw    = 8,
  parameter int unsigned       pack_n   = 2,
  parameter int unsigned       out_dw   = in_dw * pack_n,
  parameter int unsigned       line_len = 640,
  parameter int unsigned       lc_w     = 12,
  parameter logic [in_dw-1:0]  pad_val  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              s_valid,
  input  logic [in_dw-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              fifo_wen,
  output logic [out_dw-1:0] fifo_wdata,
  input  logic              fifo_wfull,
  output logic              line_done,
  output logic [lc_w-1:0]   line_cnt,
  output logic              len_err
);

  localparam int unsigned       lane_w   = (pack_n > 1) ? $clog2(pack_n) : 1;
  localparam logic [out_dw-1:0] pad_word = {pack_n{pad_val}};

  logic [lane_w-1:0] lane;
  logic [lc_w-1:0]   pix_cnt;
  logic [out_dw-1:0] acc;
  logic [out_dw-1:0] acc_ins;
  logic [out_dw-1:0] hold_data;
  logic              hold_vld;
  logic              hold_last;
  logic              wen;
  logic              accept;
  logic              end_len;
  logic              eol;
  logic              complete;

  // rst/clr gate the handshakes combinationally so nothing moves in the clearing cycle
  always_comb begin
    s_ready  = ~rst & ~clr & (~hold_vld | ~fifo_wfull);
    wen      = ~rst & ~clr & hold_vld & ~fifo_wfull;
    accept   = s_valid & s_ready;
    end_len  = (pix_cnt + lc_w'(1)) == lc_w'(line_len);
    eol      = s_last | end_len;
    complete = accept & ((lane == lane_w'(pack_n - 1)) | eol);
    acc_ins  = acc;
    for (int unsigned k = 0; k < pack_n; k++) begin
      if (lane == lane_w'(k)) begin
        acc_ins[k*in_dw +: in_dw] = s_data;
      end
    end
  end

  assign fifo_wen   = wen;
  assign fifo_wdata = hold_data;
  assign line_done  = wen & hold_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane      <= '0;
      pix_cnt   <= '0;
      acc       <= pad_word;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      hold_last <= 1'b0;
      line_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      if (wen) begin
        hold_vld <= 1'b0;
        if (hold_last) begin
          line_cnt <= line_cnt + lc_w'(1);
        end
      end
      if (accept) begin
        pix_cnt <= eol ? '0 : pix_cnt + lc_w'(1);
        if (s_last != end_len) begin
          len_err <= 1'b1;
        end
        // a completing beat overrides the hold clear above, giving back-to-back words
        if (complete) begin
          hold_data <= acc_ins;
          hold_vld  <= 1'b1;
          hold_last <= eol;
          lane      <= '0;
          acc       <= pad_word;
        end else begin
          acc  <= acc_ins;
          lane <= lane + lane_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer: vector table, directed corner sequences,
// and randomized traffic against a queue-based line/word model.
module tb_fifo_wr_packer;

  localparam int unsigned IN_DW    = 8;
  localparam int unsigned PACK_N   = 2;
  localparam int unsigned OUT_DW   = 16;
  localparam int unsigned LINE_LEN = 4;
  localparam int unsigned LC_W     = 12;

  logic              clk = 1'b0;
  logic              rst, clr, s_valid, s_last, fifo_wfull;
  logic [IN_DW-1:0]  s_data;
  logic              s_ready, fifo_wen, line_done, len_err;
  logic [OUT_DW-1:0] fifo_wdata;
  logic [LC_W-1:0]   line_cnt;
  logic              s_ready3, fifo_wen3, line_done3, len_err3;
  logic [OUT_DW-1:0] fifo_wdata3;
  logic [LC_W-1:0]   line_cnt3;

  always #5 clk = ~clk;

  fifo_wr_packer #(.in_dw(IN_DW), .pack_n(PACK_N), .out_dw(OUT_DW), .line_len(LINE_LEN),
                   .lc_w(LC_W), .pad_val(8'h00)) dut (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull),
    .line_done(line_done), .line_cnt(line_cnt), .len_err(len_err));

  fifo_wr_packer #(.in_dw(IN_DW), .pack_n(PACK_N), .out_dw(OUT_DW), .line_len(3),
                   .lc_w(LC_W), .pad_val(8'h00)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready3), .fifo_wen(fifo_wen3), .fifo_wdata(fifo_wdata3), .fifo_wfull(fifo_wfull),
    .line_done(line_done3), .line_cnt(line_cnt3), .len_err(len_err3));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: pixels of the word being built, one pending output word
  logic [7:0]  cur_q[$];
  int          m_pc;
  bit          m_hv, m_hl, m_err;
  logic [15:0] m_hw;
  int          m_lines;
  logic [15:0] wlog[$];
  bit          dlog[$];

  task automatic model_reset();
    cur_q.delete();
    m_pc = 0; m_hv = 0; m_hl = 0; m_hw = '0; m_lines = 0; m_err = 0;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit wf);
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; fifo_wfull = wf;
    #1;
    if (fifo_wen) begin
      wlog.push_back(fifo_wdata);
      dlog.push_back(line_done);
    end
  endtask

  task automatic model_check();
    bit ew;
    ew = m_hv && !fifo_wfull;
    chk("s_ready", s_ready, !m_hv || !fifo_wfull);
    chk("fifo_wen", fifo_wen, ew);
    chk("line_done", line_done, ew && m_hl);
    if (ew) chk("fifo_wdata", fifo_wdata, m_hw);
    chk("line_cnt", line_cnt, m_lines % 4096);
    chk("len_err", len_err, m_err);
  endtask

  task automatic model_update();
    bit rdy, at_len, eol;
    logic [15:0] w;
    rdy = !m_hv || !fifo_wfull;
    if (m_hv && !fifo_wfull) begin
      m_hv = 0;
      if (m_hl) m_lines++;
    end
    if (s_valid && rdy) begin
      cur_q.push_back(s_data);
      m_pc++;
      at_len = (m_pc == LINE_LEN);
      eol = s_last || at_len;
      if (s_last != at_len) m_err = 1;
      if (cur_q.size() == PACK_N || eol) begin
        w = '0;
        for (int i = 0; i < cur_q.size(); i++) w[i*8 +: 8] = cur_q[i];
        m_hw = w; m_hv = 1; m_hl = eol;
        cur_q.delete();
        if (eol) m_pc = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit wf);
    drive(v, d, l, wf);
    model_check();
    model_update();
  endtask

  task automatic do_clr(input bit v, input logic [7:0] d);
    @(negedge clk);
    clr = 1; s_valid = v; s_data = d; s_last = 0; fifo_wfull = 0;
    #1;
    chk("clr_s_ready", s_ready, 0);
    chk("clr_fifo_wen", fifo_wen, 0);
    @(negedge clk);
    clr = 0; s_valid = 0;
    model_reset();
    #1;
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          l;
    bit          wf;
    bit          e_wen;
    logic [15:0] e_wd;
    bit          e_done;
    bit          e_rdy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'h2211, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h4433, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst = 1; clr = 0; s_valid = 0; s_data = '0; s_last = 0; fifo_wfull = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fifo_wen", fifo_wen, 0);
    chk("rst_fifo_wdata", fifo_wdata, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_len_err", len_err, 0);
    @(negedge clk);
    rst = 0;

    // basic packing of one correct line
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].wf);
      chk("t1_fifo_wen", fifo_wen, tbl[i].e_wen);
      chk("t1_s_ready", s_ready, tbl[i].e_rdy);
      chk("t1_line_done", line_done, tbl[i].e_done);
      if (tbl[i].e_wen) chk("t1_fifo_wdata", fifo_wdata, tbl[i].e_wd);
      model_update();
    end
    chk("t1_line_cnt", line_cnt, 1);
    chk("t1_len_err", len_err, 0);

    // padded final word on a 3-pixel line
    do_clr(0, 8'h00);
    step(1, 8'h11, 0, 0);
    chk("t2_wen3_a", fifo_wen3, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h55, 1, 0);
    chk("t2_wen3_b", fifo_wen3, 1);
    chk("t2_wdata3_b", fifo_wdata3, 16'h2211);
    chk("t2_done3_b", line_done3, 0);
    step(0, 8'h00, 0, 0);
    chk("t2_wen3_c", fifo_wen3, 1);
    chk("t2_wdata3_c", fifo_wdata3, 16'h0055);
    chk("t2_done3_c", line_done3, 1);
    step(0, 8'h00, 0, 0);
    chk("t2_line_cnt3", line_cnt3, 1);
    chk("t2_len_err3", len_err3, 0);

    // backpressure stall on a pending word
    do_clr(0, 8'h00);
    step(1, 8'hBB, 0, 0);
    step(1, 8'hAA, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hCC, 0, 1);
      chk("t3_stall_wen", fifo_wen, 0);
      chk("t3_stall_rdy", s_ready, 0);
    end
    step(1, 8'hCC, 0, 0);
    chk("t3_rel_wen", fifo_wen, 1);
    chk("t3_rel_wdata", fifo_wdata, 16'hAABB);
    step(1, 8'hDD, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("t3_next_wdata", fifo_wdata, 16'hDDCC);
    chk("t3_next_done", line_done, 1);

    // early s_last, sticky error, clr
    do_clr(0, 8'h00);
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("t4_wdata", fifo_wdata, 16'h0201);
    chk("t4_done", line_done, 1);
    chk("t4_len_err", len_err, 1);
    step(1, 8'h07, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("t4_pad_wdata", fifo_wdata, 16'h0007);
    for (int i = 1; i <= 4; i++) step(1, 8'(8'h30 + i), (i == 4), 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t4_err_sticky", len_err, 1);
    chk("t4_line_cnt", line_cnt, 3);
    do_clr(0, 8'h00);
    chk("t4_clr_err", len_err, 0);
    chk("t4_clr_cnt", line_cnt, 0);

    // overlong line: forced end of line after line_len pixels
    wlog.delete(); dlog.delete();
    for (int i = 1; i <= 6; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t5_nwords", wlog.size(), 3);
    chk("t5_w0", wlog[0], 16'h6261);
    chk("t5_w1", wlog[1], 16'h6463);
    chk("t5_w2", wlog[2], 16'h6665);
    chk("t5_d1", dlog[1], 1);
    chk("t5_d2", dlog[2], 0);
    chk("t5_len_err", len_err, 1);
    chk("t5_line_cnt", line_cnt, 1);

    // reset mid-word, then clr with a valid beat
    do_clr(0, 8'h00);
    step(1, 8'h71, 0, 0);
    @(negedge clk);
    rst = 1; s_valid = 1; s_data = 8'h99;
    #1;
    chk("t6_rst_rdy", s_ready, 0);
    chk("t6_rst_wen", fifo_wen, 0);
    @(negedge clk);
    #1;
    chk("t6_rst_wdata", fifo_wdata, 0);
    chk("t6_rst_done", line_done, 0);
    chk("t6_rst_cnt", line_cnt, 0);
    chk("t6_rst_err", len_err, 0);
    @(negedge clk);
    rst = 0; s_valid = 0;
    model_reset();
    step(1, 8'h81, 0, 0);
    step(1, 8'h82, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t6_lane0_wdata", fifo_wdata, 16'h8281);
    do_clr(1, 8'h99);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t6_clr_wdata", fifo_wdata, 16'hA2A1);

    // randomized traffic against the model
    do_clr(0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, ($urandom % 4) == 0);
    end
    repeat (4) step(0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
